cpf_frame_sequencer: RTL
========================

Name: cpf_frame_sequencer

Overview:
Sequences CP_F frames into the FrameEncoder byte pipe (data_in, is_control_byte, is_crc_byte, crc_reset), one byte per clk.
- Accepts one frame per valid/ready handshake: status, control, address and DATA_BYTES payload bytes.
- Emits status, control, address, payload, then the CRC slot.
- Fills every gap with K28.5 commas while holding the CRC generator in reset.
- Sits between the trigger/command logic and FrameEncoder.

Parameters:
DATA_BYTES, 2, number of payload bytes per frame (>=1)
MIN_IDLE, 1, minimum comma cycles between frames, counting the acceptance cycle (>=1)
COMMA, 8'hBC, K-code byte emitted while idle (K28.5)

Ports:
clk  in  1  system clock, all logic rising-edge
reset  in  1  synchronous, active-high reset
frame_valid  in  1  requester has a frame
frame_ready  out  1  sequencer accepts a frame this cycle
status_i  in  8  status byte
control_i  in  8  control byte
address_i  in  8  address byte
payload_i  in  8*DATA_BYTES  payload; most significant byte sent first
enc_data  out  8  to FrameEncoder data_in
enc_is_control  out  1  to FrameEncoder is_control_byte
enc_is_crc  out  1  to FrameEncoder is_crc_byte
enc_crc_reset  out  1  to FrameEncoder crc_reset
busy  out  1  frame in flight (state != IDLE)
frame_done  out  1  one-cycle pulse on the CRC slot

Behaviour:
- Clock and reset: one clock (clk). reset is synchronous and active-high.
- Reset values:
  - state=IDLE, gap_cnt=MIN_IDLE-1, byte_idx=0, frame_done=0.
  - enc_data=COMMA, enc_is_control=1, enc_crc_reset=1, enc_is_crc=0.
- Output timing: all enc_* outputs, frame_done and busy are registered and describe the byte presented in the current cycle.
- frame_ready = (state==IDLE) && (gap_cnt==0). It is combinational from registers and independent of frame_valid.
- Accept: frame_valid && frame_ready at edge T.
  - All fields are captured into holding registers; inputs may change afterwards.
  - The cycle before T still shows a comma. T+1 shows status.
- States and outputs:
  - IDLE: enc_data=COMMA, enc_is_control=1, enc_crc_reset=1, enc_is_crc=0. gap_cnt decrements, saturating at 0.
  - STATUS, CONTROL, ADDR: the captured byte; is_control=0, crc_reset=0, is_crc=0.
  - DATA: payload byte[byte_idx], MSB first. byte_idx increments and leaves DATA when byte_idx==DATA_BYTES-1, then clears to 0.
  - CRC: enc_is_crc=1, enc_data=8'h00 (encoder substitutes its CRC), crc_reset=0, is_control=0, frame_done=1. gap_cnt is loaded with MIN_IDLE-1.
- Transitions: IDLE->STATUS on accept; STATUS->CONTROL->ADDR->DATA (DATA_BYTES cycles)->CRC->IDLE. No stalls mid-frame.
- CRC alignment:
  - crc_reset is high on every comma cycle, so the CRC starts from its initial value on the status byte.
  - On the CRC slot the generator output covers exactly status..last payload byte.
- Frame period at MIN_IDLE=1 is 5+DATA_BYTES cycles (7 at default), with one comma between back-to-back frames.
- Reset mid-frame: next cycle is IDLE with comma outputs. The frame is discarded; no frame_done. frame_ready returns after MIN_IDLE-1 further cycles.
- frame_valid while busy is ignored (ready=0); the requester holds its data.
- byte_idx width is max(1,clog2(DATA_BYTES)). gap_cnt width is max(1,clog2(MIN_IDLE)).

Decomposition:
- Shared package cpf_pkg holds:
  - K28_5 = 8'hBC.
  - CRC8_POLY = 8'h07 and CRC8_INIT = 8'hFF, also used by the bench model.
  - The sequencer state enum (IDLE, STATUS, CONTROL, ADDR, DATA, CRC).
- No sub-module; a single FSM plus holding registers.
- The bench instantiates cpf_frame_sequencer driving FrameEncoder.

Test Plan:
- Reset then idle 10 cycles: enc_data=8'hBC, is_control=1, crc_reset=1 every cycle. frame_ready=1 from the first post-reset cycle (MIN_IDLE=1).
- Single frame status=8'h01, control=8'h20, address=8'h05, payload=16'hA55A accepted at T:
  - T+1..T+5 enc_data = 01,20,05,A5,5A with is_control=0.
  - T+6 is_crc=1 and frame_done=1; FrameEncoder crc_o equals the model CRC-8 (0x07, init 0xFF) over 01 20 05 A5 5A.
  - T+7 comma.
- frame_valid held high continuously with MIN_IDLE=1: accepts every 7 cycles, exactly one comma between the CRC slot and the next status, and every CRC matches the model.
- MIN_IDLE=3 build: after the CRC slot, frame_ready stays low for 2 cycles and rises on the 3rd comma cycle; three commas precede the next status.
- reset asserted during the ADDR byte: the next cycle is a comma; there is no frame_done and no CRC slot for that frame. The following frame's CRC is correct.
- frame_valid pulsed while busy: no capture; inputs changed mid-frame do not alter emitted bytes.

Source files
------------

// File: rtl/cpf_pkg.sv
// Shared constants, sequencer state encoding and CRC-8 helper for the CP_F frame path.
package cpf_pkg;

    localparam logic [7:0] K28_5     = 8'hBC;
    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_STATUS  = 3'd1,
        ST_CONTROL = 3'd2,
        ST_ADDR    = 3'd3,
        ST_DATA    = 3'd4,
        ST_CRC     = 3'd5
    } seq_state_e;

    // MSB-first CRC-8 update over one byte, matching the FrameEncoder generator.
    function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/cpf_frame_sequencer.sv
// Serialises one CP_F frame per handshake into the FrameEncoder byte pipe,
// padding every gap with K28.5 commas while the CRC generator is held in reset.
module cpf_frame_sequencer
    import cpf_pkg::*;
#(
    parameter int         DATA_BYTES = 2,
    parameter int         MIN_IDLE   = 1,
    parameter logic [7:0] COMMA      = K28_5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    frame_valid,
    output logic                    frame_ready,
    input  logic [7:0]              status_i,
    input  logic [7:0]              control_i,
    input  logic [7:0]              address_i,
    input  logic [8*DATA_BYTES-1:0] payload_i,
    output logic [7:0]              enc_data,
    output logic                    enc_is_control,
    output logic                    enc_is_crc,
    output logic                    enc_crc_reset,
    output logic                    busy,
    output logic                    frame_done
);

    localparam int PW    = 8 * DATA_BYTES;
    localparam int IDX_W = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
    localparam int GAP_W = (MIN_IDLE > 1) ? $clog2(MIN_IDLE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BYTES - 1);
    localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(MIN_IDLE - 1);

    seq_state_e       state_q, state_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [IDX_W-1:0] byte_idx_q, byte_idx_d;
    logic [7:0]       status_q, status_d;
    logic [7:0]       control_q, control_d;
    logic [7:0]       address_q, address_d;
    logic [PW-1:0]    payload_q, payload_d;
    logic [7:0]       enc_data_q, enc_data_d;
    logic             enc_is_control_q, enc_is_control_d;
    logic             enc_is_crc_q, enc_is_crc_d;
    logic             enc_crc_reset_q, enc_crc_reset_d;
    logic             frame_done_q, frame_done_d;
    logic [7:0]       data_byte;

    assign frame_ready    = (state_q == ST_IDLE) && (gap_cnt_q == '0);
    assign busy           = (state_q != ST_IDLE);
    assign enc_data       = enc_data_q;
    assign enc_is_control = enc_is_control_q;
    assign enc_is_crc     = enc_is_crc_q;
    assign enc_crc_reset  = enc_crc_reset_q;
    assign frame_done     = frame_done_q;

    always_comb begin
        state_d    = state_q;
        gap_cnt_d  = gap_cnt_q;
        byte_idx_d = byte_idx_q;
        status_d   = status_q;
        control_d  = control_q;
        address_d  = address_q;
        payload_d  = payload_q;
        case (state_q)
            ST_IDLE: begin
                if (gap_cnt_q != '0) gap_cnt_d = gap_cnt_q - GAP_W'(1);
                if (frame_valid && frame_ready) begin
                    state_d   = ST_STATUS;
                    status_d  = status_i;
                    control_d = control_i;
                    address_d = address_i;
                    payload_d = payload_i;
                end
            end
            ST_STATUS:  state_d = ST_CONTROL;
            ST_CONTROL: state_d = ST_ADDR;
            ST_ADDR: begin
                state_d    = ST_DATA;
                byte_idx_d = '0;
            end
            ST_DATA: begin
                if (byte_idx_q == LAST_IDX) begin
                    state_d    = ST_CRC;
                    byte_idx_d = '0;
                end else begin
                    byte_idx_d = byte_idx_q + IDX_W'(1);
                end
            end
            ST_CRC: begin
                state_d   = ST_IDLE;
                gap_cnt_d = GAP_INIT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered pipe shows the byte of the current cycle.
    always_comb begin
        data_byte = '0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            if (byte_idx_d == IDX_W'(i)) data_byte = payload_d[PW-8-8*i +: 8];
        end
    end

    always_comb begin
        enc_data_d       = COMMA;
        enc_is_control_d = 1'b1;
        enc_crc_reset_d  = 1'b1;
        enc_is_crc_d     = 1'b0;
        frame_done_d     = 1'b0;
        case (state_d)
            ST_STATUS, ST_CONTROL, ST_ADDR, ST_DATA: begin
                enc_is_control_d = 1'b0;
                enc_crc_reset_d  = 1'b0;
                case (state_d)
                    ST_STATUS:  enc_data_d = status_d;
                    ST_CONTROL: enc_data_d = control_d;
                    ST_ADDR:    enc_data_d = address_d;
                    default:    enc_data_d = data_byte;
                endcase
            end
            ST_CRC: begin
                enc_data_d       = 8'h00;
                enc_is_control_d = 1'b0;
                enc_crc_reset_d  = 1'b0;
                enc_is_crc_d     = 1'b1;
                frame_done_d     = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            gap_cnt_q        <= GAP_INIT;
            byte_idx_q       <= '0;
            status_q         <= '0;
            control_q        <= '0;
            address_q        <= '0;
            payload_q        <= '0;
            enc_data_q       <= COMMA;
            enc_is_control_q <= 1'b1;
            enc_is_crc_q     <= 1'b0;
            enc_crc_reset_q  <= 1'b1;
            frame_done_q     <= 1'b0;
        end else begin
            state_q          <= state_d;
            gap_cnt_q        <= gap_cnt_d;
            byte_idx_q       <= byte_idx_d;
            status_q         <= status_d;
            control_q        <= control_d;
            address_q        <= address_d;
            payload_q        <= payload_d;
            enc_data_q       <= enc_data_d;
            enc_is_control_q <= enc_is_control_d;
            enc_is_crc_q     <= enc_is_crc_d;
            enc_crc_reset_q  <= enc_crc_reset_d;
            frame_done_q     <= frame_done_d;
        end
    end

endmodule
